// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - byte stream handshake between host and SPI master
// tx side carries bytes to shift out, rx side returns sampled bytes.
interface spi_master_ctrl_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_last,
    input  tx_ready,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_last,
    output tx_ready,
    output rx_valid,
    output rx_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master, one byte per handshake
// Frames span bytes until tx_last; CS_n is held low between bytes of a frame.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_ctrl_if.slave   bus,
  output logic               busy,
  output logic               CS_n,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_next;
  logic [7:0] rx_final;
  logic       last_q;
  logic       miso_q;
  logic       accept;

  assign bus.tx_ready = ((state == S_IDLE) || (state == S_NEXT)) && !rst;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign busy         = (state != S_IDLE);

  // MISO is registered at the edge that raises SCLK and folded in on the
  // first HIGH cycle; with CLK_DIV=1 that cycle is also the last one.
  always_comb begin
    rx_next  = {rx_shift[6:0], miso_q};
    rx_final = (cnt == DIV_M1) ? rx_next : rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      bit_cnt     <= 3'd0;
      tx_shift    <= 8'd0;
      rx_shift    <= 8'd0;
      last_q      <= 1'b0;
      miso_q      <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= 8'd0;
      CS_n        <= 1'b1;
      SCLK        <= 1'b0;
      MOSI        <= 1'b0;
    end else begin
      miso_q       <= MISO;
      bus.rx_valid <= 1'b0;
      case (state)
        S_IDLE, S_NEXT: begin
          if (accept) begin
            tx_shift <= bus.tx_data;
            last_q   <= bus.tx_last;
            bit_cnt  <= 3'd7;
            CS_n     <= 1'b0;
            SCLK     <= 1'b0;
            MOSI     <= bus.tx_data[7];
            if ((state == S_IDLE) && (CS_SETUP != 0)) begin
              state <= S_SETUP;
              cnt   <= SETUP_M1;
            end else begin
              state <= S_LOW;
              cnt   <= DIV_M1;
            end
          end
        end
        S_SETUP: begin
          if (cnt == 8'd0) begin
            state <= S_LOW;
            cnt   <= DIV_M1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_LOW: begin
          if (cnt == 8'd0) begin
            state <= S_HIGH;
            cnt   <= DIV_M1;
            SCLK  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (cnt == DIV_M1) begin
            rx_shift <= rx_next;
          end
          if (cnt == 8'd0) begin
            SCLK    <= 1'b0;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              bus.rx_valid <= 1'b1;
              bus.rx_data  <= rx_final;
              MOSI         <= 1'b0;
              if (last_q) begin
                CS_n  <= 1'b1;
                state <= S_GAP;
                cnt   <= GAP_M1;
              end else begin
                state <= S_NEXT;
              end
            end else begin
              MOSI     <= tx_shift[6];
              tx_shift <= {tx_shift[6:0], 1'b0};
              state    <= S_LOW;
              cnt      <= DIV_M1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == 8'd0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 The block SHALL have parameter CS_SETUP, default 1, meaning clk cycles from CS_n falling to the first SCLK rising edge beyond one CLK_DIV low phase (range 0..255).
REQ-003 The block SHALL have parameter CS_GAP, default 4, meaning the minimum clk cycles CS_n stays high between frames (range 1..255).
REQ-004 clk  input  1  system clock; the block is single clock domain and all logic runs on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 tx_valid  input  1  host offers a byte.
REQ-007 tx_ready  output  1  block accepts the byte this cycle.
REQ-008 tx_data  input  8  byte to transmit, MSB first.
REQ-009 tx_last  input  1  the accepted byte ends the frame (CS_n released afterwards).
REQ-010 rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-011 rx_data  output  8  byte sampled from MISO, MSB first.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 CS_n  output  1  active-low slave select.
REQ-014 SCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-015 MOSI  output  1  master data out.
REQ-016 MISO  input  1  slave data in; the block registers it before use.

Function
REQ-017 The block SHALL implement states IDLE, SETUP, LOW, HIGH, NEXT and GAP.
REQ-018 A transfer SHALL be accepted only on a clk edge where tx_valid and tx_ready are both high; accepting latches tx_data and tx_last.
REQ-019 tx_ready SHALL be high only in IDLE and in NEXT.
REQ-020 On an accept in IDLE, the next cycle SHALL have CS_n=0, MOSI=tx_data[7], SCLK=0, and the state SHALL be SETUP, which lasts CS_SETUP cycles (skipped if 0) before going to LOW.
REQ-021 LOW SHALL last CLK_DIV cycles with SCLK=0 and MOSI stable; on its final cycle the block samples MISO into the rx shift register and drives SCLK=1 on the following cycle (state HIGH).
REQ-022 HIGH SHALL last CLK_DIV cycles with SCLK=1; on exit SCLK=0, the 3-bit bit counter decrements, and MOSI presents the next bit.
REQ-023 Each byte SHALL have exactly 8 SCLK rising edges, and CS_n low time for a single-byte frame SHALL equal CS_SETUP + 16*CLK_DIV cycles.
REQ-024 After the 8th HIGH phase, rx_valid SHALL pulse for exactly one cycle with rx_data = the sampled byte; there is no backpressure on rx.
REQ-025 If the latched tx_last is 1, the block SHALL drive CS_n=1 and MOSI=0 in the rx_valid cycle, then enter GAP for CS_GAP cycles, then IDLE.
REQ-026 If the latched tx_last is 0, the block SHALL enter NEXT with CS_n=0 and SCLK=0; an accept in NEXT goes directly to LOW with MOSI=tx_data[7] (no SETUP), and the block waits in NEXT indefinitely otherwise.
REQ-027 tx_valid asserted outside IDLE/NEXT SHALL be ignored and have no effect on SCLK, MOSI or CS_n.
REQ-028 tx_data and tx_last changes after acceptance SHALL not affect the frame in progress.
REQ-029 With CLK_DIV=1, SCLK SHALL toggle every clk cycle and all rules above still hold.

Reset
REQ-030 While rst is high at a clk edge, outputs SHALL become CS_n=1, SCLK=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0, and the state SHALL become IDLE.
REQ-031 In the first cycle after rst deasserts, tx_ready SHALL be 1.
REQ-032 A reset during any state SHALL abort the frame without an rx_valid pulse.

Verification
REQ-033 Loopback (MISO=MOSI), defaults, tx 0xA5 with last=1 -> 8 SCLK rises, CS_n low 33 cycles, rx_valid once with rx_data=0xA5, CS_n high for at least 4 cycles before tx_ready=1.
REQ-034 Echo-slave model (returns the previous byte), frames 0xA5, 0x5A, 0xFF, 0x01, 0x00 each last=1 -> rx 0x00, 0xA5, 0x5A, 0xFF, 0x01.
REQ-035 Loopback, 3-byte frame 0x12, 0x34, 0x56 with last=0,0,1 and tx_valid held -> CS_n continuously low, 24 SCLK rises, rx 0x12, 0x34, 0x56, 3 rx_valid pulses.
REQ-036 NEXT stall: byte 0x80 last=0, then tx_valid low for 50 cycles -> CS_n stays low, SCLK stays 0, busy=1; then 0x01 last=1 -> rx 0x01, CS_n released.
REQ-037 rst asserted mid-byte (after the 4th SCLK rise) -> next cycle CS_n=1, SCLK=0, MOSI=0, no rx_valid; a new 0x3C transfer then completes correctly.
REQ-038 CLK_DIV=1, CS_SETUP=0, loopback 0xC3 -> CS_n low 16 cycles, rx_data=0xC3; tx_valid pulsed during the transfer is ignored.
